// File: rtl/div_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// div_pkg : shared states, constants and helpers for div_iter_32
// rev 1.0
// ------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Divider states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOTIENT = '1;

  // The counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Carry into bit j of a 4-bit group, in sum-of-products look-ahead form.
  // j = 4 gives the group carry-out.
  function automatic logic la_carry(input logic [3:0] g4, input logic [3:0] p4,
                                    input logic cin, input int j);
    logic gen;
    logic prp;
    gen = 1'b0;
    prp = 1'b1;
    for (int m = 3; m >= 0; m--) begin
      if (m < j) begin
        gen = gen | (prp & g4[m]);
        prp = prp & p4[m];
      end
    end
    return gen | (prp & cin);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_cla_32.sv
`default_nettype none
// ------------------------------------------------------------------
// sub_cla_32 : look-ahead subtractor, diff = a + ~b + 1, 4-bit groups
// rev 1.0
// ------------------------------------------------------------------
module sub_cla_32
  import div_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NGRP = (WIDTH + 3) / 4;
  localparam int PW   = NGRP * 4;

  logic [PW-1:0]   w_g;
  logic [PW-1:0]   w_p;
  logic [NGRP-1:0] w_gg;
  logic [NGRP-1:0] w_gp;
  logic [NGRP:0]   w_gc;

  // Pad bits above WIDTH propagate, so the top group carry-out equals
  // the carry out of bit WIDTH-1.
  assign w_g = PW'(a & ~b);
  assign w_p = PW'(a ^ ~b) | ~PW'({WIDTH{1'b1}});

  genvar k, j;
  generate
    for (k = 0; k < NGRP; k++) begin : g_grp
      assign w_gg[k] = la_carry(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
      assign w_gp[k] = &w_p[4*k +: 4];
      for (j = 0; j < 4; j++) begin : g_bit
        if (4*k + j < WIDTH) begin : g_live
          assign diff[4*k+j] = w_p[4*k+j] ^
                               la_carry(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k], j);
        end
      end
    end
  endgenerate

  always_comb begin
    w_gc[0] = 1'b1;
    for (int n = 0; n < NGRP; n++) begin
      w_gc[n+1] = w_gg[n] | (w_gp[n] & w_gc[n]);
    end
  end

  assign borrow = ~w_gc[NGRP];

endmodule
`default_nettype wire

// File: rtl/div_iter_32.sv
`default_nettype none
// ------------------------------------------------------------------
// div_iter_32 : iterative restoring divider, signed/unsigned, start/busy/done
// rev 1.0
// ------------------------------------------------------------------
module div_iter_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DZ_QUOTIENT = {WIDTH{DIV_ZERO_QUOTIENT[0]}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_sub_a;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_sub_diff;
  logic             w_sub_borrow;
  logic [WIDTH:0]   w_negr_diff;
  logic             w_negr_borrow;
  logic             w_unused;

  assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // In FIX the trial subtractor is idle and is borrowed to negate the quotient.
  assign w_sub_a = (r_state == S_FIX) ? '0 : {r_rem, r_q[WIDTH-1]};
  assign w_sub_b = (r_state == S_FIX) ? {1'b0, r_q} : {1'b0, r_dvs};

  sub_cla_32 #(.WIDTH(WIDTH + 1)) u_trial (
    .a      (w_sub_a),
    .b      (w_sub_b),
    .diff   (w_sub_diff),
    .borrow (w_sub_borrow)
  );

  sub_cla_32 #(.WIDTH(WIDTH + 1)) u_neg_rem (
    .a      ('0),
    .b      ({1'b0, r_rem}),
    .diff   (w_negr_diff),
    .borrow (w_negr_borrow)
  );

  assign w_unused = ^{w_sub_diff[WIDTH], w_negr_diff[WIDTH], w_negr_borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= is_signed & dividend[WIDTH-1];
            r_rem   <= '0;
            r_dvs   <= w_dvs_mag;
            r_cnt   <= CNT_W'(WIDTH);
            // A zero divisor parks the raw dividend in r_q for DONE.
            if (divisor == '0) begin
              r_q     <= dividend;
              r_zero  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_q     <= w_dvd_mag;
              r_zero  <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_sub_borrow) begin
            r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
          end else begin
            r_rem <= w_sub_diff[WIDTH-1:0];
          end
          r_q   <= {r_q[WIDTH-2:0], ~w_sub_borrow};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quotient  <= r_neg_q ? w_sub_diff[WIDTH-1:0] : r_q;
          r_remainder <= r_neg_r ? w_negr_diff[WIDTH-1:0] : r_rem;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          if (r_zero) begin
            r_quotient  <= DZ_QUOTIENT;
            r_remainder <= r_q;
            r_dbz       <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_32.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_div_iter_32 : scoreboard bench for div_iter_32 against an arithmetic model
// rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_iter_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_busy = 1'b0;

  div_iter_32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint da;
    longint db;
    e.due = 0;
    e.dz  = 1'b0;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else begin
      da  = longint'($signed(a));
      db  = longint'($signed(b));
      e.q = W'(da / db);
      e.r = W'(da % db);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("latency_cycle", cyc, e.due);
        check("busy_at_done", busy, 1'b0);
        check("busy_before_done", prev_busy, 1'b1);
      end
    end
    prev_busy = busy;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b, s);
    e.due = cyc + ((b == 0) ? 1 : W + 2);
    sb.push_back(e);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic pulse_ignored(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: done=0 after %0d cycles, expected 1", tag, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_quotient"}, quotient, '0);
    check({tag, "_remainder"}, remainder, '0);
    check({tag, "_div_by_zero"}, div_by_zero, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0);               wait_done("u100_7");
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done("s_m7_2");
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);         wait_done("s_7_m2");
    issue(32'h1234_5678, 32'd0, 1'b1);         wait_done("dz_signed");
    issue(32'h1234_5678, 32'd0, 1'b0);         wait_done("dz_unsigned");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("s_overflow");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done("u_max_max");

    // Starts during CALC must be ignored; then a start in the done cycle.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    pulse_ignored(32'd55, 32'd5, 1'b1);
    repeat (14) @(negedge clk);
    pulse_ignored(32'hABCD, 32'd0, 1'b0);
    wait_done("ignored_starts");
    issue(32'hFFFF_FF00, 32'd9, 1'b1);
    wait_done("back_to_back");
    issue(32'd123456789, 32'd1000, 1'b0);
    wait_done("back_to_back_2");

    // Reset part-way through an operation aborts it without a done.
    issue(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    sb.delete();
    repeat (40) @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_done("after_reset");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = $urandom_range(1, 20);
        5:       b = 32'd1;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      issue(a, b, 1'($urandom_range(0, 1)));
      wait_done("random");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
